// File: rtl/id_stall_sequencer.sv
// id_stall_sequencer
// Decode-stage hazard detector and stall sequencer. It compares the ID
// operands against the EX/MEM destinations, works out how many cycles the
// front end must hold (0, 1 or 2), and drives PC/IF-ID holds, the ID/EX
// bubble and the taken-branch flush. A small FSM carries two-cycle stalls
// (branch on a load still in EX) over a STALL cycle and a HOLD_LAST cycle.
// StallCount is a saturating count of cycles spent with the PC held.

module id_stall_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        UsesRs_ID,
  input  logic        UsesRt_ID,
  input  logic        IsBranch_ID,
  input  logic        PCSel_ID,
  input  logic [4:0]  rDest_EX,
  input  logic        RegWrite_EX,
  input  logic        MemRead_EX,
  input  logic [4:0]  rDest_MEM,
  input  logic        RegWrite_MEM,
  input  logic        MemRead_MEM,
  output logic        Stall_PC,
  output logic        Stall_IF_ID,
  output logic        Bubble_ID_EX,
  output logic        Flush_IF_ID,
  output logic        StallBusy,
  output logic [15:0] StallCount
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] STALL     = 2'd1;
  localparam logic [1:0] HOLD_LAST = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic [1:0] down_count;
  logic [1:0] down_count_next;
  logic [1:0] depth;
  logic       ex_match;
  logic       mem_match;
  logic       stall_any;
  logic       flush_any;
  logic       busy_any;

  // Operand matches; register 0 is hardwired so it never creates a hazard
  always_comb begin
    ex_match  = (UsesRs_ID && (rs_ID != 5'd0) && (rs_ID == rDest_EX) && RegWrite_EX) ||
                (UsesRt_ID && (rt_ID != 5'd0) && (rt_ID == rDest_EX) && RegWrite_EX);
    mem_match = (UsesRs_ID && (rs_ID != 5'd0) && (rs_ID == rDest_MEM) && RegWrite_MEM) ||
                (UsesRt_ID && (rt_ID != 5'd0) && (rt_ID == rDest_MEM) && RegWrite_MEM);
  end

  // Required stall depth: branches resolve in ID so they also wait on ALU
  // results in EX and on loads in MEM; other instructions only wait on loads in EX
  always_comb begin
    depth = 2'd0;
    if (IsBranch_ID && ex_match && MemRead_EX) begin
      depth = 2'd2;
    end else if ((ex_match && MemRead_EX) ||
                 (IsBranch_ID && ex_match && !MemRead_EX) ||
                 (IsBranch_ID && mem_match && MemRead_MEM)) begin
      depth = 2'd1;
    end
  end

  // Next state and outputs: Mealy in RUN, Moore in STALL/HOLD_LAST, all forced low in reset
  always_comb begin
    state_next      = state;
    down_count_next = down_count;
    stall_any       = 1'b0;
    flush_any       = 1'b0;
    busy_any        = 1'b0;
    case (state)
      RUN: begin
        if (depth != 2'd0) begin
          stall_any = 1'b1;
          if (depth == 2'd2) begin
            state_next      = STALL;
            down_count_next = 2'd1;
          end
        end else begin
          flush_any = PCSel_ID;
        end
      end
      STALL: begin
        stall_any       = 1'b1;
        busy_any        = 1'b1;
        down_count_next = down_count - 2'd1;
        if (down_count <= 2'd1) begin
          state_next = HOLD_LAST;
        end
      end
      HOLD_LAST: begin
        busy_any        = 1'b1;
        state_next      = RUN;
        down_count_next = 2'd0;
      end
      default: begin
        state_next      = RUN;
        down_count_next = 2'd0;
      end
    endcase
    if (Reset) begin
      stall_any = 1'b0;
      flush_any = 1'b0;
      busy_any  = 1'b0;
    end
  end

  assign Stall_PC     = stall_any;
  assign Stall_IF_ID  = stall_any;
  assign Bubble_ID_EX = stall_any;
  assign Flush_IF_ID  = flush_any;
  assign StallBusy    = busy_any;

  // State, down-counter and saturating stall-cycle counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= RUN;
      down_count <= 2'd0;
      StallCount <= 16'd0;
    end else begin
      state      <= state_next;
      down_count <= down_count_next;
      if (stall_any && (StallCount != 16'hFFFF)) begin
        StallCount <= StallCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_id_stall_sequencer.sv
// tb_id_stall_sequencer
// Directed bench: a table of single-instruction hazard cases applied from
// RUN after a reset, followed by hand-written multi-cycle sequences for
// load-use, branch-on-load, reset abort and counter saturation.

module tb_id_stall_sequencer;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       is_branch;
    logic       pcsel;
    logic [4:0] rd_ex;
    logic       rw_ex;
    logic       mr_ex;
    logic [4:0] rd_mem;
    logic       rw_mem;
    logic       mr_mem;
    logic       exp_stall;
    logic       exp_flush;
    logic       exp_busy_next;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [4:0]  rs_ID = '0;
  logic [4:0]  rt_ID = '0;
  logic        UsesRs_ID = 1'b0;
  logic        UsesRt_ID = 1'b0;
  logic        IsBranch_ID = 1'b0;
  logic        PCSel_ID = 1'b0;
  logic [4:0]  rDest_EX = '0;
  logic        RegWrite_EX = 1'b0;
  logic        MemRead_EX = 1'b0;
  logic [4:0]  rDest_MEM = '0;
  logic        RegWrite_MEM = 1'b0;
  logic        MemRead_MEM = 1'b0;
  logic        Stall_PC;
  logic        Stall_IF_ID;
  logic        Bubble_ID_EX;
  logic        Flush_IF_ID;
  logic        StallBusy;
  logic [15:0] StallCount;

  int total = 0;
  int bad   = 0;

  vec_t vecs [15];
  vec_t idle;

  id_stall_sequencer dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .rs_ID        (rs_ID),
    .rt_ID        (rt_ID),
    .UsesRs_ID    (UsesRs_ID),
    .UsesRt_ID    (UsesRt_ID),
    .IsBranch_ID  (IsBranch_ID),
    .PCSel_ID     (PCSel_ID),
    .rDest_EX     (rDest_EX),
    .RegWrite_EX  (RegWrite_EX),
    .MemRead_EX   (MemRead_EX),
    .rDest_MEM    (rDest_MEM),
    .RegWrite_MEM (RegWrite_MEM),
    .MemRead_MEM  (MemRead_MEM),
    .Stall_PC     (Stall_PC),
    .Stall_IF_ID  (Stall_IF_ID),
    .Bubble_ID_EX (Bubble_ID_EX),
    .Flush_IF_ID  (Flush_IF_ID),
    .StallBusy    (StallBusy),
    .StallCount   (StallCount)
  );

  // 10-unit clock period
  always #5 Clock = ~Clock;

  task automatic applyStimulus(input vec_t v);
    rs_ID        = v.rs;
    rt_ID        = v.rt;
    UsesRs_ID    = v.uses_rs;
    UsesRt_ID    = v.uses_rt;
    IsBranch_ID  = v.is_branch;
    PCSel_ID     = v.pcsel;
    rDest_EX     = v.rd_ex;
    RegWrite_EX  = v.rw_ex;
    MemRead_EX   = v.mr_ex;
    rDest_MEM    = v.rd_mem;
    RegWrite_MEM = v.rw_mem;
    MemRead_MEM  = v.mr_mem;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  // The three stall outputs must always agree
  task automatic checkStall(input string name, input logic expected);
    checkOutput({name, ".Stall_PC"}, {15'd0, Stall_PC}, {15'd0, expected});
    checkOutput({name, ".Stall_IF_ID"}, {15'd0, Stall_IF_ID}, {15'd0, expected});
    checkOutput({name, ".Bubble_ID_EX"}, {15'd0, Bubble_ID_EX}, {15'd0, expected});
  endtask

  task automatic nextCycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(idle);
    Reset = 1'b1;
    nextCycle();
    Reset = 1'b0;
  endtask

  // Builds a vector from positional fields
  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                              input logic br, input logic pcs, input logic [4:0] rde, input logic rwe,
                              input logic mre, input logic [4:0] rdm, input logic rwm, input logic mrm,
                              input logic es, input logic ef, input logic eb);
    vec_t v;
    v = '{rs, rt, urs, urt, br, pcs, rde, rwe, mre, rdm, rwm, mrm, es, ef, eb};
    return v;
  endfunction

  initial begin
    vec_t v;
    idle = '0;
    //          rs  rt urs urt br pcs rdEX rw mr rdMEM rw mr  stall flush busyNext
    vecs[0]  = mk(0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0);
    vecs[1]  = mk(8,  0, 1, 0, 0, 0,  8, 1, 1,  0, 0, 0,  1, 0, 0);
    vecs[2]  = mk(0,  0, 1, 0, 0, 0,  0, 1, 1,  0, 0, 0,  0, 0, 0);
    vecs[3]  = mk(8,  0, 0, 0, 0, 0,  8, 1, 1,  0, 0, 0,  0, 0, 0);
    vecs[4]  = mk(0,  9, 0, 1, 0, 0,  9, 0, 1,  0, 0, 0,  0, 0, 0);
    vecs[5]  = mk(0,  9, 0, 1, 1, 0,  9, 1, 1,  0, 0, 0,  1, 0, 1);
    vecs[6]  = mk(5,  0, 1, 0, 1, 0,  5, 1, 0,  0, 0, 0,  1, 0, 0);
    vecs[7]  = mk(5,  0, 1, 0, 0, 0,  5, 1, 0,  0, 0, 0,  0, 0, 0);
    vecs[8]  = mk(7,  0, 1, 0, 1, 0,  0, 0, 0,  7, 1, 1,  1, 0, 0);
    vecs[9]  = mk(7,  0, 1, 0, 1, 0,  0, 0, 0,  7, 1, 0,  0, 0, 0);
    vecs[10] = mk(7,  0, 1, 0, 0, 0,  0, 0, 0,  7, 1, 1,  0, 0, 0);
    vecs[11] = mk(3,  4, 1, 1, 1, 1,  6, 1, 1,  2, 1, 1,  0, 1, 0);
    vecs[12] = mk(5,  0, 1, 0, 1, 1,  5, 1, 0,  0, 0, 0,  1, 0, 0);
    vecs[13] = mk(3, 12, 1, 1, 1, 1, 12, 1, 1,  0, 0, 0,  1, 0, 1);
    vecs[14] = mk(0, 11, 0, 1, 0, 1, 11, 1, 1, 11, 1, 1,  1, 0, 0);

    // Outputs stay low while reset is held, even with a hazard present
    applyStimulus(vecs[13]);
    Reset = 1'b1;
    nextCycle();
    @(negedge Clock);
    checkStall("reset_hold", 1'b0);
    checkOutput("reset_hold.Flush", {15'd0, Flush_IF_ID}, 16'd0);
    checkOutput("reset_hold.Busy", {15'd0, StallBusy}, 16'd0);
    checkOutput("reset_hold.Count", StallCount, 16'd0);
    nextCycle();
    Reset = 1'b0;

    // Table: each vector from a fresh RUN state, then idle for one cycle
    for (int i = 0; i < 15; i++) begin
      doReset();
      applyStimulus(vecs[i]);
      @(negedge Clock);
      checkStall($sformatf("vec%0d", i), vecs[i].exp_stall);
      checkOutput($sformatf("vec%0d.Flush", i), {15'd0, Flush_IF_ID}, {15'd0, vecs[i].exp_flush});
      checkOutput($sformatf("vec%0d.Busy", i), {15'd0, StallBusy}, 16'd0);
      nextCycle();
      applyStimulus(idle);
      @(negedge Clock);
      checkOutput($sformatf("vec%0d.BusyNext", i), {15'd0, StallBusy}, {15'd0, vecs[i].exp_busy_next});
      checkOutput($sformatf("vec%0d.Count", i), StallCount, {15'd0, vecs[i].exp_stall});
      nextCycle();
    end

    // Load-use: one stall cycle, then the load has moved to MEM
    doReset();
    applyStimulus(mk(8, 0, 1, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0));
    @(negedge Clock);
    checkStall("loaduse.c1", 1'b1);
    nextCycle();
    applyStimulus(mk(8, 0, 1, 0, 0, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0));
    @(negedge Clock);
    checkStall("loaduse.c2", 1'b0);
    checkOutput("loaduse.Count", StallCount, 16'd1);
    nextCycle();

    // Branch on a load: RUN, STALL, HOLD_LAST, RUN; later hazards ignored until RUN
    doReset();
    applyStimulus(mk(0, 9, 0, 1, 1, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0));
    @(negedge Clock);
    checkStall("brload.run", 1'b1);
    checkOutput("brload.run.Busy", {15'd0, StallBusy}, 16'd0);
    nextCycle();
    applyStimulus(mk(0, 9, 0, 1, 1, 1, 0, 0, 0, 9, 1, 1, 0, 0, 0));
    @(negedge Clock);
    checkStall("brload.stall", 1'b1);
    checkOutput("brload.stall.Busy", {15'd0, StallBusy}, 16'd1);
    checkOutput("brload.stall.Flush", {15'd0, Flush_IF_ID}, 16'd0);
    nextCycle();
    @(negedge Clock);
    checkStall("brload.hold", 1'b0);
    checkOutput("brload.hold.Busy", {15'd0, StallBusy}, 16'd1);
    checkOutput("brload.hold.Flush", {15'd0, Flush_IF_ID}, 16'd0);
    checkOutput("brload.hold.Count", StallCount, 16'd2);
    nextCycle();
    applyStimulus(mk(0, 9, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge Clock);
    checkStall("brload.back", 1'b0);
    checkOutput("brload.back.Busy", {15'd0, StallBusy}, 16'd0);
    checkOutput("brload.back.Flush", {15'd0, Flush_IF_ID}, 16'd1);
    nextCycle();
    applyStimulus(idle);
    @(negedge Clock);
    checkOutput("brload.after.Flush", {15'd0, Flush_IF_ID}, 16'd0);
    checkOutput("brload.after.Count", StallCount, 16'd2);
    nextCycle();

    // Reset during the first STALL cycle aborts the sequence
    doReset();
    applyStimulus(mk(0, 9, 0, 1, 1, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0));
    nextCycle();
    Reset = 1'b1;
    @(negedge Clock);
    checkStall("rstmid.hi", 1'b0);
    checkOutput("rstmid.hi.Busy", {15'd0, StallBusy}, 16'd0);
    nextCycle();
    applyStimulus(idle);
    Reset = 1'b0;
    @(negedge Clock);
    checkStall("rstmid.lo", 1'b0);
    checkOutput("rstmid.lo.Busy", {15'd0, StallBusy}, 16'd0);
    checkOutput("rstmid.lo.Count", StallCount, 16'd0);
    nextCycle();
    @(negedge Clock);
    checkOutput("rstmid.lo2.Busy", {15'd0, StallBusy}, 16'd0);
    checkOutput("rstmid.lo2.Count", StallCount, 16'd0);
    nextCycle();

    // Saturation: 65534 held load-use cycles, then three more
    doReset();
    v = mk(8, 0, 1, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(v);
    repeat (65534) @(posedge Clock);
    @(negedge Clock);
    checkOutput("sat.pre", StallCount, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      @(posedge Clock);
      @(negedge Clock);
      checkOutput($sformatf("sat.%0d", k), StallCount, 16'hFFFF);
    end
    applyStimulus(idle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stall_sequencer.md
ID_STALL_SEQUENCER -- requirements
Module: id_stall_sequencer

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high. Ports are named Clock and Reset.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high.
- rs_ID  in  5  ID source register 1.
- rt_ID  in  5  ID source register 2.
- UsesRs_ID  in  1  ID instruction reads rs.
- UsesRt_ID  in  1  ID instruction reads rt.
- IsBranch_ID  in  1  ID instruction resolves a branch/jump-register in ID.
- PCSel_ID  in  1  ID branch taken.
- rDest_EX  in  5  EX destination register.
- RegWrite_EX  in  1  EX writes a register.
- MemRead_EX  in  1  EX is a load.
- rDest_MEM  in  5  MEM destination register.
- RegWrite_MEM  in  1  MEM writes a register.
- MemRead_MEM  in  1  MEM is a load.
- Stall_PC  out  1  hold the PC.
- Stall_IF_ID  out  1  hold the IF/ID register.
- Bubble_ID_EX  out  1  zero the ID/EX control signals.
- Flush_IF_ID  out  1  clear the IF/ID instruction.
- StallBusy  out  1  FSM is not in RUN.
- StallCount  out  16  saturating count of stall cycles.

Function
REQ-003 A match on operand X (rs or rt) SHALL require: UsesX_ID=1, the register is nonzero, it equals the stage's rDest, and that stage's RegWrite=1. Register 0 SHALL never match.
REQ-004 The required stall depth N SHALL be computed every cycle as follows:
- N=2: IsBranch_ID=1 and an EX match with MemRead_EX=1.
- otherwise N=1 in any of these cases:
  - any EX match with MemRead_EX=1;
  - IsBranch_ID=1 and an EX match with MemRead_EX=0;
  - IsBranch_ID=1 and a MEM match with MemRead_MEM=1.
- otherwise N=0.
REQ-005 The FSM SHALL have exactly these states: RUN, STALL, HOLD_LAST.
REQ-006 A down-counter SHALL be 2 bits wide.
REQ-007 In RUN with N=0, the FSM SHALL stay in RUN, and Stall_PC, Stall_IF_ID and Bubble_ID_EX SHALL be 0.
REQ-008 In RUN with N>=1, Stall_PC, Stall_IF_ID and Bubble_ID_EX SHALL be 1 in that same cycle (combinational, Mealy).
REQ-009 From RUN, N=1 SHALL lead to RUN at the next edge, and N=2 SHALL lead to STALL with counter=1.
REQ-010 In STALL, the three stall outputs SHALL be 1 regardless of inputs (Moore), and hazard inputs SHALL be ignored.
REQ-011 In STALL, the counter SHALL decrement each cycle. At counter=1 the FSM SHALL go to HOLD_LAST next.
REQ-012 HOLD_LAST SHALL be a single cycle: the stall outputs SHALL be 0, Flush_IF_ID SHALL be 0, and the FSM SHALL return to RUN next.
- HOLD_LAST re-synchronizes the branch operand forwarding.
- A second hazard is not evaluated until RUN.
REQ-013 Flush_IF_ID SHALL equal 1 only in RUN with N=0 and PCSel_ID=1.
REQ-014 When a hazard and PCSel_ID=1 occur in the same cycle, the stall SHALL win and Flush_IF_ID SHALL be 0, because the branch is not yet resolved.
REQ-015 StallBusy SHALL be 1 in STALL and in HOLD_LAST.
REQ-016 StallCount SHALL increment by 1 on every edge where Stall_PC=1, and SHALL saturate at 16'hFFFF with no wrap.
REQ-017 All outputs SHALL have no X or unknown value when the inputs are known.

Reset
REQ-018 While Reset=1, all of these outputs SHALL be 0: Stall_PC, Stall_IF_ID, Bubble_ID_EX, Flush_IF_ID, StallBusy.
REQ-019 At a Reset edge, the FSM SHALL go to RUN, the counter SHALL be 0, and StallCount SHALL be 0.
REQ-020 Reset asserted during STALL or HOLD_LAST SHALL abort the sequence.
- The next cycle after Reset deasserts SHALL be RUN.
- No residual stall SHALL remain.

Verification
REQ-021 Load-use: EX = lw, rDest_EX=8, RegWrite_EX=1, MemRead_EX=1; ID = add with rs_ID=8, UsesRs_ID=1 -> stall outputs =1 for exactly 1 cycle, then 0; StallCount=1.
REQ-022 Branch on a load: IsBranch_ID=1, rt_ID=9, EX = lw with rDest_EX=9 -> stall outputs =1 for 2 cycles (RUN->STALL), then HOLD_LAST with outputs 0 and StallBusy=1, then RUN; StallCount=2.
REQ-023 Register zero and collision cases:
- rs_ID=0, rDest_EX=0, EX = load -> no stall.
- Same stimulus with UsesRs_ID=0 and rs_ID=8 matching -> no stall.
REQ-024 Taken branch with no hazard: PCSel_ID=1, N=0 -> Flush_IF_ID=1 for 1 cycle. With PCSel_ID=1 and N=1 -> Flush_IF_ID=0 and stall=1.
REQ-025 Reset mid-sequence: Reset=1 in the first STALL cycle -> outputs 0 while Reset is high; RUN with StallCount=0 after release.
REQ-026 Saturation: preload 65534 stall cycles (force or long run), then 3 more -> StallCount holds at 16'hFFFF.
